// File: rtl/dac_load_sequencer.sv
// Walks every unmasked DAC channel, fetching its value from the DAC value RAM and
// handing it to the serial loader with an ack/timeout handshake; coalesces refresh requests.
module dac_load_sequencer #(
  parameter int unsigned NUM_CHAN = 32,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                update_i,
  input  logic [NUM_CHAN-1:0] skip_mask_i,
  output logic [4:0]          ram_addr_o,
  input  logic [15:0]         ram_dat_i,
  output logic [15:0]         dac_dat_o,
  output logic [4:0]          dac_chan_o,
  output logic                dac_load_o,
  input  logic                dac_ack_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [7:0]          err_cnt_o
);

  localparam int unsigned CW = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned EW = 8;
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_LOAD, S_WAIT_ACK, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic            pending_q, pending_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [CW-1:0]   dchan_q, dchan_d;
  logic            load_q, load_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [EW-1:0]   cnt_q, cnt_d;

  logic [31:0]     mask_ext_c;
  logic            skip_c, last_c, tmo_hit_c, advance_c, timeout_c, start_c;

  // Mask widened to the full 5-bit channel space so chan indexes it directly
  assign mask_ext_c = 32'(skip_mask_i);
  assign skip_c     = mask_ext_c[chan_q];
  assign last_c     = (chan_q == CW'(NUM_CHAN - 1));
  assign tmo_hit_c  = (tmo_q == TW'(TIMEOUT - 1));
  assign timeout_c  = (state_q == S_WAIT_ACK) && !dac_ack_i && tmo_hit_c;
  assign advance_c  = ((state_q == S_FETCH) && skip_c) ||
                      ((state_q == S_WAIT_ACK) && (dac_ack_i || tmo_hit_c));
  // A request that slipped in during the final DONE cycle is still honoured from IDLE
  assign start_c    = update_i || pending_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_c) state_d = S_FETCH;
      S_FETCH:    state_d = skip_c ? (last_c ? S_DONE : S_FETCH) : S_LATCH;
      S_LATCH:    state_d = S_LOAD;
      S_LOAD:     state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (advance_c) state_d = last_c ? S_DONE : S_FETCH;
      S_DONE:     state_d = pending_q ? S_FETCH : S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    chan_d    = chan_q;
    pending_d = pending_q;
    tmo_d     = tmo_q;
    dat_d     = dat_q;
    dchan_d   = dchan_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    if (update_i && (state_q != S_IDLE)) pending_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          chan_d    = '0;
          pending_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_LATCH: begin
        dat_d   = ram_dat_i;
        dchan_d = chan_q;
      end
      S_LOAD:     tmo_d = '0;
      S_WAIT_ACK: begin
        tmo_d = tmo_q + TW'(1);
        if (timeout_c) begin
          err_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + EW'(1);
        end
      end
      S_DONE: begin
        // Consuming pending; a same-cycle request keeps it armed
        if (pending_q) begin
          chan_d    = '0;
          pending_d = update_i;
        end
      end
      default: ;
    endcase
    if (advance_c && !last_c) chan_d = chan_q + CW'(1);
    load_d = (state_d == S_LOAD);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE) && !pending_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chan_q    <= '0;
      pending_q <= 1'b0;
      tmo_q     <= '0;
      dat_q     <= '0;
      dchan_q   <= '0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      chan_q    <= chan_d;
      pending_q <= pending_d;
      tmo_q     <= tmo_d;
      dat_q     <= dat_d;
      dchan_q   <= dchan_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ram_addr_o = chan_q;
  assign dac_dat_o  = dat_q;
  assign dac_chan_o = dchan_q;
  assign dac_load_o = load_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_cnt_o  = cnt_q;

endmodule

// File: tb/tb_dac_load_sequencer.sv
// Directed bench for dac_load_sequencer: RAM model, ack responder, load/done logger
// and one task per scenario with hand-computed cycle expectations.
module tb_dac_load_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        update_i = 1'b0;
  logic [31:0] skip_mask_i = '0;
  logic [4:0]  ram_addr_o;
  logic [15:0] ram_dat_i = '0;
  logic [15:0] dac_dat_o;
  logic [4:0]  dac_chan_o;
  logic        dac_load_o;
  logic        dac_ack_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [7:0]  err_cnt_o;

  dac_load_sequencer #(.NUM_CHAN(32), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .update_i(update_i), .skip_mask_i(skip_mask_i),
    .ram_addr_o(ram_addr_o), .ram_dat_i(ram_dat_i), .dac_dat_o(dac_dat_o),
    .dac_chan_o(dac_chan_o), .dac_load_o(dac_load_o), .dac_ack_i(dac_ack_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // DAC value RAM: one-cycle read latency
  logic [15:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = 16'h100 + 16'(i);
  always @(posedge clk_i) ram_dat_i <= mem[ram_addr_o];

  // Ack responder: acks the cycle after each load unless the channel is withheld
  bit   auto_ack = 1'b0;
  logic ack_next = 1'b0;
  int   noack_chan = -1;
  initial forever begin
    @(negedge clk_i);
    if (auto_ack) begin
      dac_ack_i = ack_next;
      ack_next  = dac_load_o && (int'(dac_chan_o) != noack_chan);
    end
  end

  // Logger
  int          ld_chan[$];
  logic [15:0] ld_dat[$];
  int          ld_cyc[$];
  int          done_cyc[$];
  int          err_rise = -1;
  logic        err_prev = 1'b0;
  initial forever begin
    @(negedge clk_i);
    if (dac_load_o === 1'b1) begin
      ld_chan.push_back(int'(dac_chan_o));
      ld_dat.push_back(dac_dat_o);
      ld_cyc.push_back(cyc);
    end
    if (done_o === 1'b1) done_cyc.push_back(cyc);
    if (err_o === 1'b1 && err_prev !== 1'b1) err_rise = cyc;
    err_prev = err_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    ld_chan.delete(); ld_dat.delete(); ld_cyc.delete(); done_cyc.delete();
    err_rise = -1;
  endtask

  task automatic pulse_update(output int t0);
    @(negedge clk_i);
    update_i = 1'b1;
    t0 = cyc;
    @(negedge clk_i);
    update_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int t_idle);
    t_idle = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) begin
        t_idle = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (ram_addr_o !== 5'd0)  begin errors++; $display("FAIL rst_ram_addr: got %0d want 0", ram_addr_o); end
    checks++; if (dac_dat_o !== 16'd0)  begin errors++; $display("FAIL rst_dac_dat: got %h want 0", dac_dat_o); end
    checks++; if (dac_chan_o !== 5'd0)  begin errors++; $display("FAIL rst_dac_chan: got %0d want 0", dac_chan_o); end
    checks++; if (dac_load_o !== 1'b0)  begin errors++; $display("FAIL rst_load: got %b want 0", dac_load_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b want 0", done_o); end
    checks++; if (err_o !== 1'b0)       begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
    checks++; if (err_cnt_o !== 8'd0)   begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_full_refresh();
    int t0, ti;
    clear_logs();
    noack_chan = -1; ack_next = 1'b0; auto_ack = 1'b1; skip_mask_i = '0;
    pulse_update(t0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL full_busy_rise: got %b want 1", busy_o); end
    wait_idle(400, ti);
    checks++; if (ld_chan.size() !== 32) begin errors++; $display("FAIL full_load_count: got %0d want 32", ld_chan.size()); end
    for (int i = 0; i < ld_chan.size() && i < 32; i++) begin
      checks++; if (ld_chan[i] !== i) begin errors++; $display("FAIL full_chan[%0d]: got %0d want %0d", i, ld_chan[i], i); end
      checks++; if (ld_dat[i] !== 16'h100 + 16'(i)) begin errors++; $display("FAIL full_dat[%0d]: got %h want %h", i, ld_dat[i], 16'h100 + 16'(i)); end
    end
    checks++; if (ld_cyc.size() == 0 || ld_cyc[0] !== t0 + 3) begin errors++; $display("FAIL full_first_load_cycle: got %0d want %0d", ld_cyc.size() ? ld_cyc[0] - t0 : -1, 3); end
    checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cyc.size()); end
    checks++; if (done_cyc.size() == 0 || done_cyc[0] !== t0 + 129) begin errors++; $display("FAIL full_done_cycle: got %0d want 129", done_cyc.size() ? done_cyc[0] - t0 : -1); end
    checks++; if (ti !== t0 + 130) begin errors++; $display("FAIL full_busy_fall: got %0d want 130", ti - t0); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_err: got %b want 0", err_o); end
  endtask

  task automatic test_skip_mask();
    int t0, ti;
    clear_logs();
    skip_mask_i = 32'hAAAA_AAAA;
    pulse_update(t0);
    wait_idle(400, ti);
    checks++; if (ld_chan.size() !== 16) begin errors++; $display("FAIL skip_load_count: got %0d want 16", ld_chan.size()); end
    for (int i = 0; i < ld_chan.size() && i < 16; i++) begin
      checks++; if (ld_chan[i] !== 2 * i) begin errors++; $display("FAIL skip_chan[%0d]: got %0d want %0d", i, ld_chan[i], 2 * i); end
      checks++; if (ld_dat[i] !== 16'h100 + 16'(2 * i)) begin errors++; $display("FAIL skip_dat[%0d]: got %h want %h", i, ld_dat[i], 16'h100 + 16'(2 * i)); end
    end
    checks++; if (done_cyc.size() == 0 || done_cyc[0] !== t0 + 81) begin errors++; $display("FAIL skip_done_cycle: got %0d want 81", done_cyc.size() ? done_cyc[0] - t0 : -1); end
    skip_mask_i = '0;
  endtask

  task automatic test_coalesce();
    int t0, tx, ti;
    clear_logs();
    pulse_update(t0);
    repeat (8) @(negedge clk_i);
    pulse_update(tx);
    repeat (40) @(negedge clk_i);
    pulse_update(tx);
    repeat (40) @(negedge clk_i);
    pulse_update(tx);
    wait_idle(600, ti);
    checks++; if (ld_chan.size() !== 64) begin errors++; $display("FAIL coal_load_count: got %0d want 64", ld_chan.size()); end
    for (int i = 0; i < ld_chan.size() && i < 64; i++) begin
      checks++; if (ld_chan[i] !== i % 32) begin errors++; $display("FAIL coal_chan[%0d]: got %0d want %0d", i, ld_chan[i], i % 32); end
    end
    checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL coal_done_count: got %0d want 1", done_cyc.size()); end
    checks++; if (done_cyc.size() == 0 || done_cyc[0] !== t0 + 258) begin errors++; $display("FAIL coal_done_cycle: got %0d want 258", done_cyc.size() ? done_cyc[0] - t0 : -1); end
    checks++; if (ti !== t0 + 259) begin errors++; $display("FAIL coal_busy_fall: got %0d want 259", ti - t0); end
  endtask

  task automatic test_timeout();
    int t0, ti, gap, rise;
    clear_logs();
    noack_chan = 5;
    pulse_update(t0);
    wait_idle(600, ti);
    gap  = (ld_cyc.size() > 6) ? ld_cyc[6] - ld_cyc[5] : -1;
    rise = (ld_cyc.size() > 5) ? err_rise - ld_cyc[5] : -1;
    checks++; if (gap !== 19) begin errors++; $display("FAIL tmo_ch5_to_ch6_gap: got %0d want 19", gap); end
    checks++; if (rise !== 17) begin errors++; $display("FAIL tmo_err_rise: got %0d want 17", rise); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", err_o); end
    checks++; if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL tmo_err_cnt: got %0d want 1", err_cnt_o); end
    checks++; if (ld_chan.size() !== 32) begin errors++; $display("FAIL tmo_load_count: got %0d want 32", ld_chan.size()); end
    checks++; if (ld_chan.size() < 32 || ld_chan[31] !== 31) begin errors++; $display("FAIL tmo_last_chan: got %0d want 31", ld_chan.size() ? ld_chan[ld_chan.size() - 1] : -1); end
    checks++; if (done_cyc.size() == 0 || done_cyc[0] !== t0 + 144) begin errors++; $display("FAIL tmo_done_cycle: got %0d want 144", done_cyc.size() ? done_cyc[0] - t0 : -1); end
    noack_chan = -1;
    clear_logs();
    pulse_update(t0);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b want 0", err_o); end
    checks++; if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL tmo_err_cnt_kept: got %0d want 1", err_cnt_o); end
    wait_idle(400, ti);
    checks++; if (done_cyc.size() == 0 || done_cyc[0] !== t0 + 129) begin errors++; $display("FAIL tmo_rerun_done: got %0d want 129", done_cyc.size() ? done_cyc[0] - t0 : -1); end
  endtask

  task automatic test_reset_midseq();
    int t0, tx, ti, n;
    bit found;
    clear_logs();
    noack_chan = 10;
    pulse_update(t0);
    repeat (3) @(negedge clk_i);
    pulse_update(tx);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (dac_load_o === 1'b1 && dac_chan_o === 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_reach_ch10: got 0 want 1"); end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (ram_addr_o !== 5'd0)  begin errors++; $display("FAIL rmid_ram_addr: got %0d want 0", ram_addr_o); end
    checks++; if (dac_dat_o !== 16'd0)  begin errors++; $display("FAIL rmid_dac_dat: got %h want 0", dac_dat_o); end
    checks++; if (dac_chan_o !== 5'd0)  begin errors++; $display("FAIL rmid_dac_chan: got %0d want 0", dac_chan_o); end
    checks++; if (dac_load_o !== 1'b0)  begin errors++; $display("FAIL rmid_load: got %b want 0", dac_load_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL rmid_busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0)      begin errors++; $display("FAIL rmid_done: got %b want 0", done_o); end
    checks++; if (err_o !== 1'b0)       begin errors++; $display("FAIL rmid_err: got %b want 0", err_o); end
    checks++; if (err_cnt_o !== 8'd0)   begin errors++; $display("FAIL rmid_err_cnt: got %0d want 0", err_cnt_o); end
    rst_i = 1'b0;
    n = ld_chan.size();
    repeat (40) @(negedge clk_i);
    checks++; if (ld_chan.size() !== n || n !== 11) begin errors++; $display("FAIL rmid_no_more_loads: got %0d want 11", ld_chan.size()); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmid_pending_dropped: got busy %b want 0", busy_o); end
    noack_chan = -1;
    clear_logs();
    pulse_update(t0);
    wait_idle(400, ti);
    checks++; if (ld_chan.size() == 0 || ld_chan[0] !== 0) begin errors++; $display("FAIL rmid_restart_chan: got %0d want 0", ld_chan.size() ? ld_chan[0] : -1); end
    checks++; if (ld_chan.size() !== 32) begin errors++; $display("FAIL rmid_restart_count: got %0d want 32", ld_chan.size()); end
    checks++; if (done_cyc.size() == 0 || done_cyc[0] !== t0 + 129) begin errors++; $display("FAIL rmid_restart_done: got %0d want 129", done_cyc.size() ? done_cyc[0] - t0 : -1); end
  endtask

  task automatic test_ack_ignored();
    int t0, ti;
    clear_logs();
    auto_ack = 1'b0; ack_next = 1'b0; dac_ack_i = 1'b0;
    @(negedge clk_i);
    dac_ack_i = 1'b1;
    repeat (3) @(negedge clk_i);
    dac_ack_i = 1'b0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ign_idle_busy: got %b want 0", busy_o); end
    checks++; if (ram_addr_o !== 5'd31) begin errors++; $display("FAIL ign_idle_addr: got %0d want 31", ram_addr_o); end
    checks++; if (ld_chan.size() !== 0) begin errors++; $display("FAIL ign_idle_loads: got %0d want 0", ld_chan.size()); end
    pulse_update(t0);
    repeat (2) @(negedge clk_i);
    checks++; if (dac_load_o !== 1'b1) begin errors++; $display("FAIL ign_load_cycle: got %b want 1", dac_load_o); end
    dac_ack_i = 1'b1;
    @(negedge clk_i);
    dac_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (ram_addr_o !== 5'd0) begin errors++; $display("FAIL ign_load_no_advance: got %0d want 0", ram_addr_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ign_load_busy: got %b want 1", busy_o); end
    checks++; if (dac_chan_o !== 5'd0) begin errors++; $display("FAIL ign_load_chan: got %0d want 0", dac_chan_o); end
    dac_ack_i = 1'b1;
    @(negedge clk_i);
    dac_ack_i = 1'b0;
    checks++; if (ram_addr_o !== 5'd1) begin errors++; $display("FAIL ign_wait_ack_advance: got %0d want 1", ram_addr_o); end
    ack_next = 1'b0;
    auto_ack = 1'b1;
    wait_idle(400, ti);
    checks++; if (ld_chan.size() !== 32) begin errors++; $display("FAIL ign_load_count: got %0d want 32", ld_chan.size()); end
    checks++; if (done_cyc.size() == 0 || done_cyc[0] !== t0 + 131) begin errors++; $display("FAIL ign_done_cycle: got %0d want 131", done_cyc.size() ? done_cyc[0] - t0 : -1); end
  endtask

  initial begin
    test_reset();
    test_full_refresh();
    test_skip_mask();
    test_coalesce();
    test_timeout();
    test_reset_midseq();
    test_ack_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_load_sequencer.md
# dac_load_sequencer

Sequences a full refresh of the board's DAC channels from the DAC value RAM into the serial DAC loader. It sits between the host-side register block, which issues a one-cycle update strobe and owns the DAC value RAM, and the serial DAC shifter, which accepts one channel at a time. It walks every unmasked channel in order and handles the load/acknowledge handshake with a timeout. Updates requested during a refresh are coalesced into exactly one follow-on refresh.

## Interface
Parameters:
- NUM_CHAN, 32: number of DAC channels walked per refresh (2..32).
- TIMEOUT, 1024: cycles in WAIT_ACK before an acknowledge is declared missing.

Ports:
- clk_i  in  1  system clock (33 MHz local bus clock); all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- update_i  in  1  one-cycle refresh request (register-block update strobe).
- skip_mask_i  in  NUM_CHAN  bit n high: channel n is not loaded; sampled when each channel is evaluated.
- ram_addr_o  out  5  DAC value RAM read address (current channel).
- ram_dat_i  in  16  DAC value RAM read data; valid one cycle after ram_addr_o.
- dac_dat_o  out  16  value presented to the serial loader.
- dac_chan_o  out  5  channel presented to the serial loader.
- dac_load_o  out  1  one-cycle load strobe; dac_dat_o and dac_chan_o are valid on this cycle.
- dac_ack_i  in  1  one-cycle completion pulse from the serial loader.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle pulse when a refresh sequence, including any coalesced follow-on, finishes.
- err_o  out  1  sticky timeout flag.
- err_cnt_o  out  8  count of timeouts, saturating at 255.

## Operation
- States: IDLE, FETCH, LATCH, LOAD, WAIT_ACK, DONE.
- IDLE:
  - When update_i is high: chan is set to 0, pending is set to 0, err_o is cleared, and the next state is FETCH.
  - err_cnt_o is not cleared by update_i; only rst_i clears it.
- FETCH:
  - ram_addr_o equals chan.
  - If skip_mask_i[chan] is high, the channel is skipped and the machine advances (see the advance rule).
  - Otherwise the next state is LATCH.
- LATCH: ram_dat_i is captured into dac_dat_o, and chan is captured into dac_chan_o. Next state is LOAD.
- LOAD: dac_load_o is high for exactly one cycle, the timeout counter is cleared, and the next state is WAIT_ACK.
- WAIT_ACK:
  - On dac_ack_i, the machine advances.
  - If dac_ack_i has not arrived when the timeout counter reaches TIMEOUT-1:
    - err_o is set;
    - err_cnt_o is incremented, saturating at 255;
    - the machine advances.
  - dac_ack_i is ignored in every state except WAIT_ACK.
- Advance rule: if chan equals NUM_CHAN-1, the next state is DONE. Otherwise chan is incremented and the next state is FETCH.
- DONE:
  - If pending is set, pending is cleared, chan is set to 0, the next state is FETCH, and no done_o pulse is issued.
  - Otherwise done_o pulses and the next state is IDLE.
- pending:
  - Set by update_i in any state other than IDLE, including the DONE cycle.
  - Multiple requests collapse into one follow-on refresh.
  - If update_i arrives on the same cycle DONE consumes pending, pending remains set, so one further refresh follows.
- dac_dat_o and dac_chan_o hold their last loaded values between loads.

## Timing
- Reset values: state IDLE; chan 0; pending 0; timeout counter 0.
- Reset values of outputs: ram_addr_o 0, dac_dat_o 0, dac_chan_o 0, dac_load_o 0, busy_o 0, done_o 0, err_o 0, err_cnt_o 0.
- rst_i mid-sequence returns to IDLE on the next edge and drops any pending request. No dac_load_o is issued after the reset edge.
- Cycle numbering, with update_i high at cycle 0:
  - busy_o rises at cycle 1;
  - FETCH at cycle 1, LATCH at cycle 2;
  - dac_load_o high at cycle 3 for channel 0.
- If dac_ack_i arrives at cycle 4, channel 1 enters FETCH at cycle 5.
- Per-channel cost is 4 cycles plus ack latency. A skipped channel costs 1 cycle.
- With immediate acks and no masking, done_o pulses at cycle 4·NUM_CHAN+1 (129 for NUM_CHAN=32), and busy_o falls one cycle later.
- With all channels masked: there are no load strobes, DONE is reached at cycle NUM_CHAN+1, and done_o pulses on that cycle.
- Timeout: WAIT_ACK is entered at cycle t, and the advance occurs at cycle t+TIMEOUT-1. err_o is visible on the following cycle.
- chan arithmetic is 5 bits and never wraps past NUM_CHAN-1.

## Test plan
- Reset, then a single update_i; ack 1 cycle after each load, no mask:
  - 32 dac_load_o pulses with dac_chan_o = 0..31 in order;
  - dac_dat_o equals the RAM contents (preload RAM with value = 0x100 + channel);
  - done_o pulses at cycle 129; err_o stays 0.
- skip_mask_i = 0xAAAAAAAA:
  - only even channels 0,2,...,30 are loaded (16 strobes);
  - done_o arrives after 16 loads plus 16 skip cycles.
- update_i pulsed 3 times during a refresh:
  - exactly two full sequences (64 loads);
  - one done_o, at the end of the second sequence;
  - busy_o stays high between the two sequences.
- TIMEOUT=16, with no ack for channel 5:
  - channel 5 advances 15 cycles after entering WAIT_ACK;
  - err_o goes to 1 and err_cnt_o to 1;
  - channels 6..31 still load;
  - the next update_i clears err_o and leaves err_cnt_o at 1.
- rst_i asserted while in WAIT_ACK for channel 10, with pending set:
  - the next cycle shows all outputs at their reset values;
  - there are no further loads;
  - a subsequent update_i starts again from channel 0.
- dac_ack_i pulsed during IDLE and during LOAD: ignored, with no advance and no change in channel.
